acc_file: RTL

Parametrised accumulator file for the CSE 664 datapath. Holds `NUM_ACC` signed accumulators of `WIDTH` bits. Each write loads one entry from one of four sources: sign-extended immediate, register data, ALU result, or immediate shift-in. The shift-in source builds a full-width constant over several instructions. The block sits between the register file/ALU and the ALU's A-operand input, and generalises the single 8-bit accumulator with a 3-way source mux.

---
 rtl/acc_file.sv | 126 ++++++++++++
 1 files changed

// File: rtl/acc_file.sv
// acc_file: a bank of NUM_ACC signed accumulators, each WIDTH bits wide,
// with one valid bit per entry. One entry (wr_idx) can be cleared or loaded
// per clock. A load takes one of four sources: the sign-extended immediate,
// register data, the ALU result, or an immediate shift-in. The shift-in
// source builds a full-width constant over several instructions. The read
// port is purely combinational from the stored entries and has no
// write-to-read bypass.
//
// Ports:
//   clk        rising-edge clock
//   clb        synchronous active-low reset
//   load_acc   load entry wr_idx from the source chosen by sel_acc
//   clr_acc    clear entry wr_idx (wins over load_acc)
//   sel_acc    00 immediate, 01 data_in, 10 alu_out, 11 shift-in
//   wr_idx     entry written by load/clear
//   rd_idx     entry presented on acc_out
//   data_in    register file data
//   alu_out    ALU result
//   immediate  immediate field
//   acc_out    contents of entry rd_idx (0 if rd_idx is out of range)
//   acc_zero   acc_out == 0
//   acc_neg    sign bit of acc_out
//   acc_valid  entry rd_idx has been loaded since the last reset/clear
module acc_file #(
  parameter int WIDTH   = 8,
  parameter int IMM_W   = 4,
  parameter int NUM_ACC = 2,
  localparam int IDX_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic              clk,
  input  logic              clb,
  input  logic              load_acc,
  input  logic              clr_acc,
  input  logic [1:0]        sel_acc,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic [IMM_W-1:0]  immediate,
  output logic [WIDTH-1:0]  acc_out,
  output logic              acc_zero,
  output logic              acc_neg,
  output logic              acc_valid
);

  typedef enum logic [1:0] {
    SRC_IMM   = 2'b00,
    SRC_DATA  = 2'b01,
    SRC_ALU   = 2'b10,
    SRC_SHIFT = 2'b11
  } src_e;

  logic [WIDTH-1:0]   acc_q [NUM_ACC];
  logic [NUM_ACC-1:0] valid_q;

  logic [WIDTH-1:0]   wr_old;
  logic [WIDTH-1:0]   imm_sext;
  logic [WIDTH-1:0]   imm_zext;
  logic [WIDTH-1:0]   src_val;

  // Current contents of the entry being written; the shift-in source
  // always builds on this, independent of which entry is being read.
  // An out-of-range wr_idx matches no entry, so nothing is selected.
  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (wr_idx == IDX_W'(i)) begin
        wr_old = acc_q[i];
      end
    end
  end

  assign imm_sext = {{(WIDTH-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign imm_zext = {{(WIDTH-IMM_W){1'b0}}, immediate};

  // Shift-in silently discards the bits pushed off the top.
  always_comb begin
    src_val = imm_sext;
    case (src_e'(sel_acc))
      SRC_IMM:   src_val = imm_sext;
      SRC_DATA:  src_val = data_in;
      SRC_ALU:   src_val = alu_out;
      SRC_SHIFT: src_val = (wr_old << IMM_W) | imm_zext;
      default:   src_val = imm_sext;
    endcase
  end

  // Only the addressed entry is touched; an out-of-range wr_idx matches
  // no entry, so clear and load are dropped for it.
  always_ff @(posedge clk) begin
    if (!clb) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_q[i]   <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          if (clr_acc) begin
            acc_q[i]   <= '0;
            valid_q[i] <= 1'b0;
          end else if (load_acc) begin
            acc_q[i]   <= src_val;
            valid_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // An out-of-range rd_idx reads as an empty, zero entry.
  always_comb begin
    acc_out   = '0;
    acc_valid = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        acc_out   = acc_q[i];
        acc_valid = valid_q[i];
      end
    end
  end

  assign acc_zero = (acc_out == '0);
  assign acc_neg  = acc_out[WIDTH-1];

endmodule
